conv_maxpool2x2: RTL

Streaming 2x2 max-pooling stage (stride 1) placed directly downstream of the 2x2 convolution engine. It consumes the convolution engine's raster-ordered 8-bit feature-map values and buffers one map row. Each time a complete 2x2 neighbourhood is available, it emits the maximum of that neighbourhood. It also produces a per-frame sum of all pooled outputs for the host-side checker.

---
 rtl/conv_maxpool2x2.sv | 134 +++++++++++++
 1 files changed

// File: rtl/conv_maxpool2x2.sv
// conv_maxpool2x2
//   Streaming 2x2 max-pool (stride 1) behind the 2x2 convolution engine.
//   Samples arrive in raster order, one per cycle at most. One map row is
//   held in a line buffer. Every sample at (row>=1, col>=1) closes a 2x2
//   window, and the maximum of that window is emitted one cycle later.
//   A running sum of the pooled values is published when each frame ends.
//
// Parameters
//   MAP_W, MAP_H : feature-map width / height (both >= 2)
//   DATA_W       : unsigned sample width
//   SUM_W        : frame-sum accumulator width (wraps modulo 2^SUM_W)
//
// Ports
//   CLK        : clock, rising edge
//   RST        : synchronous active-high reset
//   in_valid   : in_data holds the next raster-ordered sample
//   in_data    : convolution result
//   out_valid  : out_data holds a pooled value (single-cycle pulse)
//   out_data   : 2x2 maximum
//   out_last   : final pooled value of the frame (only with out_valid)
//   sum_valid  : pulse; sum_out has just been updated
//   sum_out    : sum of all pooled values of the last completed frame
module conv_maxpool2x2 #(
  parameter int MAP_W  = 3,
  parameter int MAP_H  = 3,
  parameter int DATA_W = 8,
  parameter int SUM_W  = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              sum_valid,
  output logic [SUM_W-1:0]  sum_out
);

  localparam int CW = $clog2(MAP_W);
  localparam int RW = $clog2(MAP_H);
  localparam logic [CW-1:0] COL_LAST = CW'(MAP_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(MAP_H - 1);

  // Previous row. It is never cleared: row 0 of every frame rewrites each
  // entry before any pooled value depends on it.
  logic [DATA_W-1:0] lb [0:MAP_W-1];

  logic [CW-1:0]     col_reg;
  logic [RW-1:0]     row_reg;
  logic [DATA_W-1:0] prev_cur_reg;  // sample at (row, col-1)
  logic [DATA_W-1:0] prev_up_reg;   // sample at (row-1, col-1)
  logic [SUM_W-1:0]  acc_reg;

  logic [DATA_W-1:0] lb_rd;         // sample at (row-1, col)
  logic [DATA_W-1:0] max_up;
  logic [DATA_W-1:0] max_cur;
  logic [DATA_W-1:0] pool_max;
  logic              col_last;
  logic              row_last;
  logic              emit;
  logic              frame_end;
  logic [CW-1:0]     col_next;
  logic [RW-1:0]     row_next;
  logic [SUM_W-1:0]  acc_next;

  always_comb begin
    lb_rd    = lb[col_reg];
    max_up   = (prev_up_reg  >= lb_rd)   ? prev_up_reg  : lb_rd;
    max_cur  = (prev_cur_reg >= in_data) ? prev_cur_reg : in_data;
    pool_max = (max_up >= max_cur) ? max_up : max_cur;

    col_last = (col_reg == COL_LAST);
    row_last = (row_reg == ROW_LAST);

    // Row 0 is the fill phase and column 0 has no left neighbour:
    // neither produces a pooled value.
    emit      = in_valid && (row_reg != '0) && (col_reg != '0);
    frame_end = emit && col_last && row_last;

    col_next = col_last ? '0 : col_reg + CW'(1);
    row_next = row_reg;
    if (col_last) begin
      row_next = row_last ? '0 : row_reg + RW'(1);
    end

    acc_next = acc_reg + SUM_W'(pool_max);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      col_reg      <= '0;
      row_reg      <= '0;
      prev_cur_reg <= '0;
      prev_up_reg  <= '0;
      acc_reg      <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      sum_valid    <= 1'b0;
      out_data     <= '0;
      sum_out      <= '0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      sum_valid <= 1'b0;
      if (in_valid) begin
        col_reg      <= col_next;
        row_reg      <= row_next;
        prev_cur_reg <= in_data;
        prev_up_reg  <= lb_rd;
        if (emit) begin
          out_valid <= 1'b1;
          out_data  <= pool_max;
          if (frame_end) begin
            out_last  <= 1'b1;
            sum_valid <= 1'b1;
            sum_out   <= acc_next;
            acc_reg   <= '0;
          end else begin
            acc_reg <= acc_next;
          end
        end
      end
    end
  end

  // Line buffer write: the read above uses the old entry in the same cycle.
  always_ff @(posedge CLK) begin
    if (!RST && in_valid) begin
      lb[col_reg] <= in_data;
    end
  end

endmodule
